// File: rtl/stbuf_pkg.sv
// Shared types and sizing for the data-memory store buffer.
//   ld_state_t  - load sequencer states
//   st_entry_t  - one posted store: word address plus write data
//   STBUF_*     - default geometry used by the top level and the FIFO
package stbuf_pkg;

  localparam int STBUF_DEPTH = 4;
  localparam int STBUF_AW    = 32;
  localparam int STBUF_DW    = 32;
  localparam int STBUF_PTR_W = $clog2(STBUF_DEPTH);

  typedef enum logic [2:0] {IDLE, DRAIN, RREQ, RWAIT, DONE} ld_state_t;

  typedef struct packed {
    logic [STBUF_AW-3:0] adr;
    logic [STBUF_DW-1:0] wd;
  } st_entry_t;

endpackage

// File: rtl/stbuf_fifo.sv
// Circular FIFO of posted stores.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   push, push_entry  enqueue request and entry (ignored when full)
//   pop               dequeue request (ignored when empty)
//   head              oldest entry
//   full, empty       occupancy flags
//   count             number of valid entries
//   entries, valid    (STBUF_FWD_EN only) all slots in age order, oldest at
//                     index 0, with a valid bit per slot for the forwarding CAM
module stbuf_fifo
  import stbuf_pkg::*;
#(
  parameter int  DEPTH = STBUF_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  st_entry_t                push_entry,
  output st_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [PW:0]              count
`ifdef STBUF_FWD_EN
  ,
  output st_entry_t [DEPTH-1:0]    entries,
  output logic      [DEPTH-1:0]    valid
`endif
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  st_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity comes from count and the
  // pointers, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

`ifdef STBUF_FWD_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign entries[k] = mem[rd_ptr + PW'(k)];
    assign valid[k]   = ((PW+1)'(k) < count);
  end
`endif

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between a single-cycle core and a slow memory.
// Stores retire into a FIFO and drain in order; loads wait for the FIFO to
// empty, issue a read and stall the core until the data returns.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cpu_we, cpu_re             store / load request (never both; load wins)
//   cpu_adr, cpu_wd            byte address (bits [1:0] ignored), store data
//   cpu_rd                     load data, valid when cpu_re=1 and cpu_stall=0
//   cpu_stall                  combinational hold for the core
//   mem_req, mem_we            request valid, 1=write drain / 0=read
//   mem_adr, mem_wd            word-aligned address, write data
//   mem_ready                  memory accepts the request this cycle
//   mem_rvalid, mem_rdata      read data return
// Build option:
//   STBUF_FWD_EN  loads in IDLE that hit a buffered store are answered from the
//                 youngest matching entry without stalling.
// AW and DW must match the widths of stbuf_pkg::st_entry_t.
module dmem_store_buffer
  import stbuf_pkg::*;
#(
  parameter int DEPTH = STBUF_DEPTH,
  parameter int AW    = STBUF_AW,
  parameter int DW    = STBUF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);

  st_entry_t     push_entry;
  st_entry_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW:0]   fifo_count;
  logic          push;
  logic          pop;
  ld_state_t     state;
  ld_state_t     state_nxt;
  logic          stall_raw;
  logic [DW-1:0] rd_q;
  logic          fwd_hit;
  logic          unused_adr_lsb;

  assign unused_adr_lsb = ^cpu_adr[1:0];

  // A simultaneous load and store is resolved in favour of the load.
  assign push_entry = '{adr: cpu_adr[AW-1:2], wd: cpu_wd};
  assign push       = cpu_we & ~cpu_re & ~fifo_full;
  // The head is always being offered while the FIFO holds anything.
  assign pop        = ~fifo_empty & mem_ready;

`ifdef STBUF_FWD_EN
  st_entry_t [DEPTH-1:0] fifo_entries;
  logic      [DEPTH-1:0] fifo_valid;
  logic      [DW-1:0]    fwd_wd;
`endif

  stbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
`ifdef STBUF_FWD_EN
    ,
    .entries    (fifo_entries),
    .valid      (fifo_valid)
`endif
  );

`ifdef STBUF_FWD_EN
  // Entries are presented oldest-first, so the last match is the youngest.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_wd  = '0;
    if (state == IDLE && cpu_re) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (fifo_valid[k] && fifo_entries[k].adr == cpu_adr[AW-1:2]) begin
          fwd_hit = 1'b1;
          fwd_wd  = fifo_entries[k].wd;
        end
      end
    end
  end

  assign cpu_rd = fwd_hit ? fwd_wd : rd_q;
`else
  assign fwd_hit = 1'b0;
  assign cpu_rd  = rd_q;
`endif

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_re && !fwd_hit) begin
          stall_raw = 1'b1;
          // A load never passes an older store: drain first if needed.
          state_nxt = (fifo_count != '0) ? DRAIN : RREQ;
        end else if (cpu_we && !cpu_re && fifo_full) begin
          // Held store is retried; a same-cycle pop does not free it early.
          stall_raw = 1'b1;
        end
      end
      DRAIN: begin
        stall_raw = 1'b1;
        if (fifo_count == '0) state_nxt = RREQ;
      end
      RREQ: begin
        stall_raw = 1'b1;
        // FIFO is empty here, so mem_ready belongs to the read.
        if (mem_ready) state_nxt = RWAIT;
      end
      RWAIT: begin
        stall_raw = 1'b1;
        if (mem_rvalid) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is forced low while reset is asserted, whatever the core drives.
  assign cpu_stall = stall_raw & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rd_q  <= '0;
    end else begin
      state <= state_nxt;
      // Only a response to our own outstanding read is captured.
      if (state == RWAIT && mem_rvalid) rd_q <= mem_rdata;
    end
  end

  // The drain owns the channel whenever the FIFO is non-empty.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_wd  = '0;
    if (!fifo_empty) begin
      mem_req = 1'b1;
      mem_we  = 1'b1;
      mem_adr = {head.adr, 2'b00};
      mem_wd  = head.wd;
    end else if (state == RREQ) begin
      mem_req = 1'b1;
      mem_adr = {cpu_adr[AW-1:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model
// (pending-store queue, architectural and physical memory images).
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_adr, cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_adr, mem_wd;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_adr    (cpu_adr),
    .cpu_wd     (cpu_wd),
    .cpu_rd     (cpu_rd),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_wd     (mem_wd),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset) assert (!(cpu_we && cpu_re));

  // ---------------- reference model ----------------
  typedef struct { logic [29:0] a; logic [31:0] d; } st_t;
  typedef struct { logic we; logic [31:0] adr; logic [31:0] wd; } txn_t;

  st_t         q[$];                    // stores accepted, not yet in memory
  logic [31:0] phys [logic [29:0]];     // what the memory really holds
  logic [31:0] arch [logic [29:0]];     // what program order says it holds
  int          ld;       // 0 none, 1 waiting for drain, 2 read offered, 3 read in flight, 4 data returned
  int          rv_delay;
  logic [31:0] rv_data;
  bit          hold_rv, force_rv;
  int          fixed_delay = -1;
  txn_t        dlog[$];                 // transactions accepted on the DUT port

  int   n_vec = 0, n_bad = 0;
  logic last_stall;
  logic s_stall, s_req, s_we, s_ready;
  logic [31:0] s_adr, s_wd, s_rd;

  function automatic logic [31:0] init_word(logic [29:0] a);
    return {a[15:0], 16'h5EED} ^ 32'h0F0F_0000;
  endfunction

  function automatic logic [31:0] phys_rd(logic [29:0] a);
    return phys.exists(a) ? phys[a] : init_word(a);
  endfunction

  function automatic logic [31:0] arch_rd(logic [29:0] a);
    return arch.exists(a) ? arch[a] : init_word(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: inputs are already set (we are just past a negedge).
  task automatic step();
    logic        exp_stall, exp_req, exp_we;
    logic [31:0] exp_adr, exp_wd;
    bit          hit;
    int          sz;
    hit = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (force_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD;
    end else if (reset && ld == 3 && !hold_rv && rv_delay == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rv_data;
    end
    #1;
    s_stall = cpu_stall; s_req = mem_req; s_we = mem_we; s_ready = mem_ready;
    s_adr = mem_adr; s_wd = mem_wd; s_rd = cpu_rd;
    if (!reset) begin
      exp_stall = 1'b0;
      check("rst_cpu_stall", s_stall, 0);
      check("rst_mem_req",   s_req,   0);
      check("rst_mem_we",    s_we,    0);
      check("rst_mem_adr",   s_adr,   0);
      check("rst_mem_wd",    s_wd,    0);
      check("rst_cpu_rd",    s_rd,    0);
    end else begin
`ifdef STBUF_FWD_EN
      if (ld == 0 && cpu_re)
        foreach (q[k]) if (q[k].a == cpu_adr[31:2]) hit = 1;
`endif
      case (ld)
        0:       exp_stall = cpu_re ? !hit : (cpu_we && q.size() == DEPTH);
        1, 2, 3: exp_stall = 1'b1;
        default: exp_stall = 1'b0;
      endcase
      exp_req = (q.size() != 0) || (ld == 2);
      if (q.size() != 0) begin
        exp_we = 1'b1; exp_adr = {q[0].a, 2'b00}; exp_wd = q[0].d;
      end else begin
        exp_we = 1'b0; exp_adr = {cpu_adr[31:2], 2'b00}; exp_wd = 32'h0;
      end
      check("cpu_stall", s_stall, exp_stall);
      check("mem_req",   s_req,   exp_req);
      if (exp_req) begin
        check("mem_we",  s_we,  exp_we);
        check("mem_adr", s_adr, exp_adr);
        if (exp_we) check("mem_wd", s_wd, exp_wd);
      end
      if (cpu_re && !exp_stall) check("cpu_rd", s_rd, arch_rd(cpu_adr[31:2]));
    end
    last_stall = exp_stall;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      ld = 0;
      arch = phys;          // pending stores are lost
    end else begin
      if (s_req && s_ready) dlog.push_back('{we: s_we, adr: s_adr, wd: s_wd});
      sz = q.size();
      case (ld)
        0: if (cpu_re && !hit) ld = (sz != 0) ? 1 : 2;
        1: if (sz == 0) ld = 2;
        2: if (mem_ready) begin
             ld = 3;
             rv_data  = phys_rd(cpu_adr[31:2]);
             rv_delay = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 2);
           end
        3: if (mem_rvalid) ld = 4;
           else if (!hold_rv && rv_delay > 0) rv_delay--;
        default: ld = 0;
      endcase
      if (sz != 0 && mem_ready) begin
        phys[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (cpu_we && !cpu_re && sz < DEPTH) begin
        q.push_back('{a: cpu_adr[31:2], d: cpu_wd});
        arch[cpu_adr[31:2]] = cpu_wd;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain_idle();
    cpu_we = 1'b0; cpu_re = 1'b0;
    for (int i = 0; i < 40; i++) begin
      mem_ready = 1'b1;
      step();
      if (q.size() == 0 && ld == 0) begin
        check("idle_mem_req", mem_req, 0);
        return;
      end
    end
    check("drain_idle_bound", q.size(), 0);
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_adr = a; cpu_wd = d;
  endtask

  task automatic finish_load();
    int guard = 0;
    while (last_stall && guard < 50) begin
      mem_ready = 1'b1;
      step();
      guard++;
    end
    check("load_bound", last_stall, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    int n;
    ea = '{32'h10, 32'h14, 32'h18};
    ed = '{32'hA, 32'hB, 32'hC};
    reset = 1'b0; cpu_we = 0; cpu_re = 0; cpu_adr = 0; cpu_wd = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    ld = 0; rv_delay = 0; rv_data = 0; hold_rv = 0; force_rv = 0; last_stall = 0;
    @(negedge clk);

    // 1: reset with random inputs, then release
    for (int i = 0; i < 5; i++) begin
      cpu_we = $urandom_range(0, 1); cpu_re = !cpu_we && $urandom_range(0, 1);
      cpu_adr = $urandom; cpu_wd = $urandom; mem_ready = $urandom_range(0, 1);
      step();
    end
    reset = 1'b1; cpu_we = 0; cpu_re = 0; mem_ready = 0;
    step();
    check("rel_stall", s_stall, 0);
    check("rel_req",   s_req,   0);

    // 2: drain order with mem_ready every second cycle
    dlog.delete();
    for (int i = 0; i < 3; i++) begin
      store(ea[i], ed[i]);
      mem_ready = i[0];
      step();
    end
    cpu_we = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      mem_ready = ~mem_ready;
      step();
    end
    check("t2_nwrites", dlog.size(), 3);
    for (int i = 0; i < 3 && i < dlog.size(); i++) begin
      check("t2_we",  dlog[i].we,  1);
      check("t2_adr", dlog[i].adr, ea[i]);
      check("t2_wd",  dlog[i].wd,  ed[i]);
    end
    drain_idle();

    // 3: full buffer stalls the fifth store until a slot frees
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      store(32'h100 + 4 * i, 32'h500 + i);
      step();
      check("t3_stall", s_stall, (i == 4) ? 1 : 0);
    end
    mem_ready = 1'b1;
    step();
    check("t3_stall_pop_cycle", s_stall, 1);
    mem_ready = 1'b0;
    step();
    check("t3_stall_released", s_stall, 0);
    drain_idle();

`ifndef STBUF_FWD_EN
    // 4: load after store waits for the drain, then reads
    dlog.delete();
    mem_ready = 1'b0;
    store(32'h64, 32'h7);
    step();
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_adr = 32'h64;
    step();
    finish_load();
    check("t4_cpu_rd", s_rd, 32'h7);
    check("t4_ntxn", dlog.size(), 2);
    if (dlog.size() >= 2) begin
      check("t4_wr_we",  dlog[0].we,  1);
      check("t4_wr_adr", dlog[0].adr, 32'h64);
      check("t4_wr_wd",  dlog[0].wd,  32'h7);
      check("t4_rd_we",  dlog[1].we,  0);
      check("t4_rd_adr", dlog[1].adr, 32'h64);
    end
    drain_idle();
`else
    // 5: forwarding from the youngest matching entry, then a miss
    mem_ready = 1'b0;
    store(32'h64, 32'h5); step();
    store(32'h64, 32'h7); step();
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_adr = 32'h64;
    step();
    check("t5_hit_stall", s_stall, 0);
    check("t5_hit_rd",    s_rd,    32'h7);
    check("t5_port_is_write", s_we, 1);
    cpu_adr = 32'h68;
    step();
    check("t5_miss_stall", s_stall, 1);
    finish_load();
    drain_idle();
`endif

    // 6: reset during RWAIT, then a stray rvalid
    cpu_re = 1'b1; cpu_adr = 32'h40; mem_ready = 1'b1; hold_rv = 1;
    step(); step(); step();
    check("t6_rwait_stall", s_stall, 1);
    reset = 1'b0; cpu_re = 1'b0;
    step();
    reset = 1'b1; hold_rv = 0; force_rv = 1;
    step();
    force_rv = 0;
    check("t6_cpu_rd",  cpu_rd,    0);
    check("t6_stall",   cpu_stall, 0);
    check("t6_mem_req", mem_req,   0);

    // minimum load latency from an empty buffer
    fixed_delay = 0;
    cpu_re = 1'b1; cpu_adr = 32'h44; mem_ready = 1'b1;
    n = 0;
    for (int g = 0; g < 20; g++) begin
      step();
      if (s_stall) n++;
      if (!last_stall) break;
    end
    check("min_latency_stalls", n, 3);
    fixed_delay = -1;
    drain_idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0; cpu_we = 0; cpu_re = 0;
        step();
        reset = 1'b1;
      end
      if (!last_stall) begin
        int r = $urandom_range(0, 9);
        cpu_we  = (r < 4);
        cpu_re  = (r >= 4 && r < 7);
        cpu_adr = 32'h60 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3);
        cpu_wd  = $urandom;
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
